// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master and slave ports.
package bus_pkg;

  localparam int unsigned BUS_N   = 8;
  localparam int unsigned BUS_ADN = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    ADDR   = 3'd2,
    RDWAIT = 3'd3,
    RDDATA = 3'd4,
    DONE   = 3'd5
  } busState_t;

endpackage

// File: rtl/bus_shift_reg.sv
// MSB-first shift register: parallel load, serial out from the MSB, serial in at the LSB.
module bus_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] loadData,
  input  logic         shiftEn,
  input  logic         serialIn,
  output logic         serialOut,
  output logic [W-1:0] parallelOut
);

  logic [W-1:0] data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data <= '0;
    end else if (load) begin
      data <= loadData;
    end else if (shiftEn) begin
      data <= {data[W-2:0], serialIn};
    end
  end

  assign serialOut   = data[W-1];
  assign parallelOut = data;

endmodule

// File: rtl/bus_master_port.sv
// Initiator-side serial bus port: serialises host requests, deserialises read responses.
// Optional read timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned N       = BUS_N,
  parameter int unsigned ADN     = BUS_ADN,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           req,
  input  logic           req_wr,
  input  logic [ADN-1:0] req_addr,
  input  logic [N-1:0]   req_wdata,
  output logic           req_ready,
  output logic           rsp_valid,
  output logic [N-1:0]   rsp_rdata,
  output logic           rsp_err,
  output logic           validIn,
  output logic           wren,
  output logic           Address,
  output logic           DataIn,
  input  logic           ready,
  input  logic           validOut,
  input  logic           DataOut
);

  localparam int unsigned CW = $clog2(ADN) + 1;

  busState_t     state, stateNext;
  logic [CW-1:0] bitCnt, bitCntNext;
  logic          wrReg;
  logic          accept, addrTake, dataTake, rxShift, rxBit;
  logic          addrSerial, dataSerial;
  logic [N-1:0]  rxWord;
  logic          reqReadyNext, rspValidNext, validInNext, wrenNext, addressNext, dataInNext;
  logic [N-1:0]  rspRdataNext;
  logic          timeoutHit;
  logic [ADN-1:0] unusedAddrPar;
  logic [N-1:0]   unusedDataPar;
  logic           unusedRxSerial;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] waitCnt;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT;
`endif

  assign rxBit = validOut & DataOut;

  // Next state, counters and next registered outputs
  always_comb begin
    stateNext    = state;
    bitCntNext   = bitCnt;
    accept       = 1'b0;
    timeoutHit   = 1'b0;
    addrTake     = 1'b0;
    dataTake     = 1'b0;
    rxShift      = 1'b0;
    validInNext  = 1'b0;
    wrenNext     = 1'b0;
    addressNext  = 1'b0;
    dataInNext   = 1'b0;
    rspRdataNext = '0;

    case (state)
      IDLE: begin
        if (req && ready) begin
          accept    = 1'b1;
          stateNext = HDR;
        end
      end
      HDR: begin
        stateNext  = ADDR;
        bitCntNext = '0;
      end
      ADDR: begin
        if (bitCnt == CW'(ADN - 1)) begin
          stateNext  = wrReg ? DONE : RDWAIT;
          bitCntNext = '0;
        end else begin
          bitCntNext = bitCnt + CW'(1);
        end
      end
      RDWAIT: begin
        if (validOut) begin
          stateNext  = RDDATA;
          bitCntNext = '0;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        else if (waitCnt == TW'(TIMEOUT - 1)) begin
          stateNext  = DONE;
          timeoutHit = 1'b1;
        end
`endif
      end
      RDDATA: begin
        rxShift = 1'b1;
        if (bitCnt == CW'(N - 1)) begin
          stateNext    = DONE;
          rspRdataNext = {rxWord[N-2:0], rxBit};
        end else begin
          bitCntNext = bitCnt + CW'(1);
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Output registers take the value belonging to the state being entered
    if (stateNext == HDR) begin
      validInNext = 1'b1;
      wrenNext    = req_wr;
    end else if (stateNext == ADDR) begin
      validInNext = 1'b1;
      wrenNext    = wrReg;
      addrTake    = 1'b1;
      addressNext = addrSerial;
      dataTake    = wrReg && (bitCntNext >= CW'(ADN - N));
      dataInNext  = dataTake & dataSerial;
    end

    reqReadyNext = (stateNext == IDLE);
    rspValidNext = (stateNext == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      bitCnt    <= '0;
      wrReg     <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      validIn   <= 1'b0;
      wren      <= 1'b0;
      Address   <= 1'b0;
      DataIn    <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      wrReg     <= accept ? req_wr : wrReg;
      req_ready <= reqReadyNext;
      rsp_valid <= rspValidNext;
      rsp_rdata <= rspRdataNext;
      validIn   <= validInNext;
      wren      <= wrenNext;
      Address   <= addressNext;
      DataIn    <= dataInNext;
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  // RDWAIT cycle counter and error flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      waitCnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      waitCnt <= (state == RDWAIT) ? waitCnt + TW'(1) : '0;
      rsp_err <= timeoutHit;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  bus_shift_reg #(.W(ADN)) addrSr (
    .clk(clk), .rstn(rstn), .load(accept), .loadData(req_addr),
    .shiftEn(addrTake), .serialIn(1'b0),
    .serialOut(addrSerial), .parallelOut(unusedAddrPar)
  );

  bus_shift_reg #(.W(N)) dataSr (
    .clk(clk), .rstn(rstn), .load(accept), .loadData(req_wdata),
    .shiftEn(dataTake), .serialIn(1'b0),
    .serialOut(dataSerial), .parallelOut(unusedDataPar)
  );

  bus_shift_reg #(.W(N)) rxSr (
    .clk(clk), .rstn(rstn), .load(accept), .loadData('0),
    .shiftEn(rxShift), .serialIn(rxBit),
    .serialOut(unusedRxSerial), .parallelOut(rxWord)
  );

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port with a transaction-level host/target model.
module tb_bus_master_port;

  localparam int unsigned N   = 8;
  localparam int unsigned ADN = 12;
`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic req = 1'b0;
  logic req_wr = 1'b0;
  logic [ADN-1:0] req_addr = '0;
  logic [N-1:0] req_wdata = '0;
  logic ready = 1'b0;
  logic validOut = 1'b0;
  logic DataOut = 1'b0;
  logic req_ready, rsp_valid, rsp_err, validIn, wren, Address, DataIn;
  logic [N-1:0] rsp_rdata;

  int nChecks = 0;
  int nPass = 0;
  logic [N-1:0] refMem [int];
  logic [N-1:0] slaveMem [int];

  always #5 clk = ~clk;

  bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .validIn(validIn), .wren(wren),
    .Address(Address), .DataIn(DataIn), .ready(ready), .validOut(validOut),
    .DataOut(DataOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // One host transaction with a target that answers reads after `delay` idle cycles
  task automatic runTxn(input logic wr, input logic [ADN-1:0] addr, input logic [N-1:0] wd,
                        input int delay, input int bitsSent, input int holdoff,
                        input bit holdReq, input int abortAt);
    logic [ADN-1:0] capAddr = '0;
    logic [N-1:0] capData = '0;
    logic [N-1:0] gotRd = '0;
    logic [N-1:0] expRd;
    logic [N-1:0] word;
    logic gotErr = 1'b0;
    logic expErr;
    bit hdrBad = 0, wrenBad = 0, dinBad = 0, errStray = 0, quietBad = 0;
    int vCount = 0, rspT = 0, tA = 0, nRsp = 0, marker, expLat, e;

    word = refMem.exists(int'(addr)) ? refMem[int'(addr)] : '0;
    check("idle_ready", 32'(req_ready), 32'(1));
    req = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    ready = (holdoff == 0);
    for (int h = 1; h <= holdoff; h++) begin
      @(negedge clk);
      check("holdoff", 32'({req_ready, validIn}), 32'(2'b10));
      if (h == holdoff) ready = 1'b1;
    end

    for (int t = 1; t <= 40 + delay; t++) begin
      @(negedge clk);
      if (!holdReq) req = 1'b0;
      if (abortAt > 0 && t == abortAt + 1) begin
        check("rst_vin", 32'(validIn), 32'(0));
        check("rst_ready", 32'(req_ready), 32'(1));
        check("rst_rsp", 32'(rsp_valid), 32'(0));
        rstn = 1'b1; req = 1'b0;
        for (int q = 0; q < 20; q++) begin
          @(negedge clk);
          quietBad |= rsp_valid | validIn;
        end
        check("rst_quiet", 32'(quietBad), 32'(0));
        return;
      end
      if (validIn) begin
        vCount++;
        if (vCount == 1) hdrBad |= Address | DataIn;
        else begin
          capAddr = {capAddr[ADN-2:0], Address};
          if (vCount - 1 > int'(ADN - N)) capData = {capData[N-2:0], DataIn};
          else dinBad |= DataIn;
        end
        if (vCount == int'(ADN) + 1) tA = t;
      end else begin
        dinBad |= DataIn;
      end
      wrenBad |= (wren !== (validIn ? wr : 1'b0));
      if (rsp_valid) begin
        nRsp++;
        if (nRsp == 1) begin rspT = t; gotRd = rsp_rdata; gotErr = rsp_err; end
      end else begin
        errStray |= rsp_err;
      end
      if (abortAt > 0 && t == abortAt) begin
        check("pre_rst_vin", 32'(validIn), 32'(1));
        rstn = 1'b0;
      end
      if (rspT > 0 && t == rspT + 1) begin
        check("done_ready", 32'(req_ready), 32'(1));
        break;
      end
      marker = tA + 1 + delay;
      if (!wr && tA > 0 && t >= marker && t <= marker + int'(N)) begin
        validOut = (t == marker) || (t - marker <= bitsSent);
        if (t != marker && validOut)
          DataOut = (slaveMem.exists(int'(addr)) ? slaveMem[int'(addr)][N - (t - marker)] : 1'b0);
        else
          DataOut = 1'($urandom);
      end else begin
        validOut = 1'b0;
        DataOut = 1'($urandom);
      end
      ready = 1'($urandom);
    end
    validOut = 1'b0;

    if (wr && vCount == int'(ADN) + 1) slaveMem[int'(capAddr)] = capData;
    if (wr) refMem[int'(addr)] = wd;

    expErr = 1'b0;
    expRd = '0;
    if (wr) expLat = int'(ADN) + 2;
`ifdef BUS_MASTER_TIMEOUT_EN
    else if (delay >= int'(TO)) begin expLat = int'(ADN) + 2 + int'(TO); expErr = 1'b1; end
`endif
    else begin
      expLat = int'(ADN) + 1 + delay + 1 + int'(N) + 1;
      e = int'(word);
      e = (e >> (int'(N) - bitsSent)) << (int'(N) - bitsSent);
      expRd = N'(e);
    end

    check("rsp_seen", 32'(rspT > 0), 32'(1));
    check("vin_cycles", 32'(vCount), 32'(ADN + 1));
    check("hdr_bits", 32'(hdrBad), 32'(0));
    check("addr_bits", 32'(capAddr), 32'(addr));
    check("wdata_bits", 32'(capData), 32'(wr ? wd : '0));
    check("din_idle", 32'(dinBad), 32'(0));
    check("wren", 32'(wrenBad), 32'(0));
    check("latency", 32'(rspT), 32'(expLat));
    check("rdata", 32'(gotRd), 32'(expRd));
    check("err", 32'(gotErr), 32'(expErr));
    check("err_stray", 32'(errStray), 32'(0));
    check("rsp_pulses", 32'(nRsp), 32'(1));
    if (wr) check("slave_mem", 32'(slaveMem[int'(addr)]), 32'(wd));
  endtask

  initial begin
    logic [ADN-1:0] pool [4];
    logic [ADN-1:0] a;
    pool[0] = 12'h5A3; pool[1] = 12'h010; pool[2] = 12'hFFF; pool[3] = 12'h000;

    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({req_ready, rsp_valid, rsp_err, validIn, wren, Address, DataIn}),
          32'(7'b1000000));
    check("rst_rdata", 32'(rsp_rdata), 32'(0));
    rstn = 1'b1;
    @(negedge clk);

    runTxn(1'b1, 12'h5A3, 8'hC5, 0, N, 0, 1'b0, 0);
    runTxn(1'b0, 12'h5A3, 8'h00, 20, N, 0, 1'b0, 0);
    runTxn(1'b1, 12'h123, 8'h9E, 0, N, 0, 1'b1, 0);
    runTxn(1'b0, 12'h123, 8'h00, 3, N, 0, 1'b0, 0);
    runTxn(1'b1, 12'h0F0, 8'h5A, 0, N, 5, 1'b0, 0);
    runTxn(1'b1, 12'h7FF, 8'hFF, 0, N, 0, 1'b0, 7);
    runTxn(1'b1, 12'h010, 8'h3C, 0, N, 0, 1'b0, 0);
    runTxn(1'b0, 12'h010, 8'h00, 0, N, 0, 1'b0, 0);
    runTxn(1'b0, 12'h010, 8'h00, 2, 5, 0, 1'b0, 0);
    runTxn(1'b0, 12'h7FF, 8'h00, 1, N, 0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : ADN'($urandom);
      runTxn(1'($urandom), a, N'($urandom), $urandom_range(0, 6),
             $urandom_range(N - 2, N), $urandom_range(0, 3), 1'b0, 0);
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    runTxn(1'b0, 12'h5A3, 8'h00, 1000, N, 0, 1'b0, 0);
    runTxn(1'b0, 12'h5A3, 8'h00, TO - 1, N, 0, 1'b0, 0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
